// File: rtl/aes_ctrl_pkg.sv
// Shared types and defaults for the AES-128 round sequencer.
package aes_ctrl_pkg;
  localparam int AES128_NUM_ROUNDS = 10;
  localparam int AES_STAGE_LAT     = 3;
  localparam int ROUND_IDX_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_KEY,
    ROUND,
    DONE
  } aes_ctrl_state_t;
endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 core: walks the datapath through
// the initial key add plus NUM_ROUNDS rounds, fetching one round key per round,
// and hands the finished block out over a valid/ready handshake. Control only.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_NUM_ROUNDS,
  parameter int STAGE_LAT  = AES_STAGE_LAT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic                   abort,
  output logic                   key_req,
  input  logic                   key_ack,
  output logic                   load_sel,
  output logic                   state_en,
  output logic                   skip_mix,
  output logic [ROUND_IDX_W-1:0] round_idx,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [ROUND_IDX_W-1:0] LAST_ROUND = ROUND_IDX_W'(NUM_ROUNDS);
  localparam logic [ROUND_IDX_W-1:0] LAST_STAGE = ROUND_IDX_W'(STAGE_LAT - 1);

  aes_ctrl_state_t        state_q, state_d;
  logic [ROUND_IDX_W-1:0] round_q, round_d;
  logic [ROUND_IDX_W-1:0] stage_q, stage_d;
  logic                   last_stage;
  logic                   final_round;

  assign last_stage  = (stage_q == LAST_STAGE);
  assign final_round = (round_q == LAST_ROUND);

  // State, round index and stage counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      stage_q <= stage_d;
    end
  end

  // Next-state logic; abort overrides every transition, including a start in IDLE.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: begin
        round_d = '0;
        stage_d = '0;
        if (start_valid) state_d = LOAD;
      end
      LOAD: state_d = WAIT_KEY;
      WAIT_KEY: begin
        // round_idx advances only once the next key is actually present
        if (key_ack) begin
          state_d = ROUND;
          round_d = round_q + 1'b1;
          stage_d = '0;
        end
      end
      ROUND: begin
        if (last_stage) begin
          stage_d = '0;
          state_d = final_round ? DONE : WAIT_KEY;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
        stage_d = '0;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      round_d = '0;
      stage_d = '0;
    end
  end

  // Moore output decode from state register and stage counter.
  always_comb begin
    start_ready = 1'b0;
    key_req     = 1'b0;
    load_sel    = 1'b0;
    state_en    = 1'b0;
    skip_mix    = 1'b0;
    busy        = 1'b1;
    out_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      LOAD: begin
        load_sel = 1'b1;
        state_en = 1'b1;
        key_req  = 1'b1;
      end
      ROUND: begin
        skip_mix = final_round;
        if (last_stage) begin
          state_en = 1'b1;
          key_req  = !final_round;
        end
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign round_idx = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a schedule-based model builds the expected output
// trace for each directed scenario, and every cycle of the DUT is compared to it.
module tb_aes_round_ctrl;

  typedef struct packed {
    logic       start_ready;
    logic       key_req;
    logic       load_sel;
    logic       state_en;
    logic       skip_mix;
    logic       busy;
    logic       out_valid;
    logic [3:0] round_idx;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, abort, out_ready;
  logic sv_a, sv_b, ka_a, ka_b;
  logic a_sr, a_kr, a_ls, a_se, a_sm, a_bz, a_ov;
  logic b_sr, b_kr, b_ls, b_se, b_sm, b_bz, b_ov;
  logic [3:0] a_ri, b_ri;
  outs_t oa, ob;

  assign oa = {a_sr, a_kr, a_ls, a_se, a_sm, a_bz, a_ov, a_ri};
  assign ob = {b_sr, b_kr, b_ls, b_se, b_sm, b_bz, b_ov, b_ri};

  aes_round_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start_valid(sv_a), .start_ready(a_sr),
    .abort(abort), .key_req(a_kr), .key_ack(ka_a), .load_sel(a_ls),
    .state_en(a_se), .skip_mix(a_sm), .round_idx(a_ri), .busy(a_bz),
    .out_valid(a_ov), .out_ready(out_ready)
  );

  aes_round_ctrl #(.NUM_ROUNDS(1), .STAGE_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_valid(sv_b), .start_ready(b_sr),
    .abort(abort), .key_req(b_kr), .key_ack(ka_b), .load_sel(b_ls),
    .state_en(b_se), .skip_mix(b_sm), .round_idx(b_ri), .busy(b_bz),
    .out_valid(b_ov), .out_ready(out_ready)
  );

  int vecs = 0;
  int errs = 0;

  outs_t exp_tr [0:299];
  bit    sv_tr  [0:299];
  bit    ab_tr  [0:299];
  bit    or_tr  [0:299];
  int    n_tr;
  int    first_valid;

  function automatic outs_t mk(bit sr, bit kr, bit ls, bit se, bit sm, bit bz, bit ov, int ri);
    outs_t o;
    o = {sr, kr, ls, se, sm, bz, ov, 4'(ri)};
    return o;
  endfunction

  outs_t IDLE_O;
  initial IDLE_O = mk(1, 0, 0, 0, 0, 0, 0, 0);

  task automatic push(outs_t o);
    exp_tr[n_tr] = o;
    sv_tr[n_tr]  = 1'b0;
    ab_tr[n_tr]  = 1'b0;
    or_tr[n_tr]  = 1'b1;
    n_tr++;
  endtask

  // Expected trace from the block's schedule: start, load, then per round
  // (d+1) key-wait cycles followed by sl datapath stages, then the output hold.
  // cut truncates the block (abort/reset) and idle cycles follow.
  task automatic build(int nr, int sl, int d, int hold, int cut, int pad);
    n_tr = 0;
    push(IDLE_O);
    sv_tr[0] = 1'b1;
    push(mk(0, 1, 1, 1, 0, 1, 0, 0));
    for (int r = 1; r <= nr; r++) begin
      for (int w = 0; w <= d; w++) push(mk(0, 0, 0, 0, 0, 1, 0, r - 1));
      for (int s = 0; s < sl; s++)
        push(mk(0, (s == sl - 1) && (r < nr), 0, s == sl - 1, r == nr, 1, 0, r));
    end
    first_valid = n_tr;
    for (int h = 0; h <= hold; h++) begin
      push(mk(0, 0, 0, 0, 0, 1, 1, nr));
      or_tr[n_tr - 1] = (h == hold);
    end
    if (cut >= 0) n_tr = cut + 1;
    for (int p = 0; p < pad; p++) push(IDLE_O);
  endtask

  task automatic check(outs_t a, outs_t e, string nm, int c);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s cycle %0d: got sr=%b kr=%b ls=%b se=%b sm=%b bz=%b ov=%b ri=%0d, want sr=%b kr=%b ls=%b se=%b sm=%b bz=%b ov=%b ri=%0d",
               nm, c, a.start_ready, a.key_req, a.load_sel, a.state_en, a.skip_mix, a.busy,
               a.out_valid, a.round_idx, e.start_ready, e.key_req, e.load_sel, e.state_en,
               e.skip_mix, e.busy, e.out_valid, e.round_idx);
    end
  endtask

  task automatic pin(string nm, int got, int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Drives the scenario trace, answers key requests after d extra cycles and
  // compares the selected DUT against the model on every cycle.
  task automatic run(bit sel, int d, int rst_at, int want_se, int want_kr);
    int    due = -1;
    int    cse = 0;
    int    ckr = 0;
    outs_t cur;
    for (int c = 0; c < n_tr; c++) begin
      @(negedge clk);
      cur = sel ? ob : oa;
      check(cur, exp_tr[c], "trace", c);
      if (cur.state_en) cse++;
      if (cur.key_req) ckr++;
      if (sel) begin
        sv_b = sv_tr[c];
        ka_b = (c == due);
      end else begin
        sv_a = sv_tr[c];
        ka_a = (c == due);
      end
      abort     = ab_tr[c];
      out_ready = or_tr[c];
      if (cur.key_req) due = c + 1 + d;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        cur = sel ? ob : oa;
        check(cur, IDLE_O, "async_reset", c);
      end else if (c == rst_at + 1) begin
        rst_n = 1'b1;
      end
    end
    sv_a = 0; sv_b = 0; ka_a = 0; ka_b = 0; abort = 0; out_ready = 0;
    if (want_se >= 0) begin
      pin("state_en_count", cse, want_se);
      pin("key_req_count", ckr, want_kr);
    end
  endtask

  initial begin
    rst_n = 0; abort = 0; out_ready = 0;
    sv_a = 0; sv_b = 0; ka_a = 0; ka_b = 0;
    repeat (2) @(negedge clk);
    check(oa, IDLE_O, "reset_a", 0);
    check(ob, IDLE_O, "reset_b", 0);
    rst_n = 1;

    // single block, defaults, key_ack right after each request
    build(10, 3, 0, 0, -1, 4);
    pin("model_latency_default", first_valid, 42);
    pin("model_skip_mix_r10", int'(exp_tr[39].skip_mix), 1);
    pin("model_skip_mix_r9", int'(exp_tr[37].skip_mix), 0);
    run(0, 0, -1, 11, 10);

    // key_ack three cycles late every round
    build(10, 3, 3, 0, -1, 4);
    pin("model_latency_ack3", first_valid, 72);
    run(0, 3, -1, 11, 10);

    // backpressure: out_ready low 5 cycles, start offered in the leaving cycle
    build(10, 3, 0, 5, -1, 4);
    sv_tr[first_valid + 5] = 1'b1;
    run(0, 0, -1, 11, 10);

    // abort in round 4 stage 1, then a clean block
    build(10, 3, 0, 0, 16, 4);
    pin("model_abort_round", int'(exp_tr[16].round_idx), 4);
    ab_tr[16] = 1'b1;
    run(0, 0, -1, -1, -1);
    build(10, 3, 0, 0, -1, 4);
    run(0, 0, -1, 11, 10);

    // abort while waiting for a key; the late ack must be ignored
    build(10, 3, 3, 0, 3, 6);
    ab_tr[3] = 1'b1;
    run(0, 3, -1, -1, -1);

    // reset asserted in WAIT_KEY
    build(10, 3, 0, 0, 2, 4);
    run(0, 0, 2, -1, -1);

    // abort with start_valid in IDLE: no accept, then a normal start
    build(10, 3, 0, 0, 0, 4);
    ab_tr[0] = 1'b1;
    run(0, 0, -1, -1, -1);
    build(10, 3, 0, 0, -1, 4);
    run(0, 0, -1, 11, 10);

    // minimum configuration: one round, one stage
    build(1, 1, 0, 0, -1, 4);
    pin("model_latency_min", first_valid, 4);
    run(1, 0, -1, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES-128 encryption core. It accepts a start request and steps the registered round datapath (SubBytes, ShiftRows, MixColumns/AddRoundKey; one clock each) through the initial key add and 10 rounds. It requests each round key from the key-expansion unit and presents the finished block through a valid/ready output handshake. It owns no data, only control: state-register enable, load select, final-round MixColumns bypass and round index.

## Interface
- NUM_ROUNDS, default 10: rounds after the initial key add; legal range 1..15.
- STAGE_LAT, default 3: datapath clocks per round, from state register to state register; legal range 1..15.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  new block (plaintext + key) available at the datapath inputs.
- start_ready  out  1  controller idle and able to accept a start.
- abort  in  1  synchronous cancel; priority over everything.
- key_req  out  1  one-cycle pulse requesting round key round_idx+1.
- key_ack  in  1  requested round key is stable on the datapath key input.
- load_sel  out  1  state register input = plaintext XOR key0 (else datapath result).
- state_en  out  1  capture enable for the state register.
- skip_mix  out  1  bypass MixColumns (final round only).
- round_idx  out  4  current round number, 0 = initial key add.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  ciphertext valid in the state register.
- out_ready  in  1  consumer accepts ciphertext.

## Operation
- Moore FSM. States: IDLE, LOAD, WAIT_KEY, ROUND, DONE. Outputs are decoded from the state register plus stage counter.
- **IDLE**
  - start_ready=1.
  - start_valid & start_ready moves to LOAD.
- **LOAD** (1 cycle)
  - load_sel=1, state_en=1, round_idx=0, key_req=1.
  - Moves to WAIT_KEY.
- **WAIT_KEY**
  - Holds until key_ack=1.
  - Then moves to ROUND with round_idx+1 and stage_cnt=0.
  - key_ack is ignored in every other state.
- **ROUND**
  - stage_cnt counts 0..STAGE_LAT-1.
  - On the last stage: state_en=1.
  - On the last stage with round_idx<NUM_ROUNDS: key_req=1, then WAIT_KEY.
  - On the last stage with round_idx==NUM_ROUNDS: move to DONE.
  - skip_mix=1 throughout ROUND when round_idx==NUM_ROUNDS; 0 otherwise.
- **DONE**
  - out_valid=1, held until out_ready=1.
  - Then IDLE. No new start is accepted in the same cycle.
- **abort**
  - Any non-IDLE state goes to IDLE next cycle; round_idx and stage_cnt clear.
  - A pending key request is dropped; a late key_ack is ignored.
  - abort together with start_valid in IDLE: start is not accepted.
- **Counts per block:** exactly NUM_ROUNDS+1 state_en pulses and NUM_ROUNDS key_req pulses.
- **Counter widths:** round_idx and stage_cnt are 4-bit and never wrap under the legal parameter ranges.

## Timing
- **Reset values** (state = IDLE):
  - start_ready=1.
  - key_req, load_sel, state_en, skip_mix, busy, out_valid = 0.
  - round_idx=0.
- Reset asserted mid-block returns to IDLE immediately (asynchronous). No out_valid follows.
- **Latency**, with key_ack high in the cycle after each key_req:
  - Accept edge = cycle 0; LOAD = cycle 1.
  - Each round takes 1+STAGE_LAT cycles.
  - out_valid first high at cycle 2 + NUM_ROUNDS*(1+STAGE_LAT) = 42 for the defaults.
- Each cycle of key_ack delay adds exactly one cycle per round.
- out_valid stays high with round_idx=NUM_ROUNDS while out_ready=0. This is unbounded backpressure.
- Throughput: one block per 43 cycles minimum (DONE→IDLE→accept).

## Structure
- Package aes_ctrl_pkg holds:
  - state enum aes_ctrl_state_t (IDLE, LOAD, WAIT_KEY, ROUND, DONE);
  - AES128_NUM_ROUNDS=10;
  - AES_STAGE_LAT=3;
  - round index width 4.
- No sub-module. FSM, round counter and stage counter stay in one module.

## Test plan
- **Single block, defaults, key_ack always 1:** start at cycle 0 → out_valid at cycle 42; 11 state_en pulses, 10 key_req pulses; skip_mix high only while round_idx=10.
- **key_ack delayed 3 cycles after every key_req:** out_valid at cycle 42+30=72; round_idx sequence 0..10 unchanged.
- **out_ready held low 5 cycles in DONE:** out_valid stays high for 5 cycles, round_idx=10, start_ready=0; returns to IDLE the cycle after out_ready.
- **abort in round 4 stage 1:** next cycle IDLE, busy=0, round_idx=0, no further key_req or state_en. A following start completes normally in 42 cycles.
- **rst_n low in WAIT_KEY, then release; plus abort with start_valid in IDLE:**
  - After reset release, all outputs are at reset values.
  - When abort and start_valid are both high, start is not accepted.
- **NUM_ROUNDS=1, STAGE_LAT=1:** out_valid at cycle 4; skip_mix high in the only round.
